// File: rtl/pipe_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_muldiv_ctrl                                                 |
// | Brief   : HI/LO owner; iterative 32-step multiply / restoring divide      |
// |           sequencer with ID stall. Define PIPE_MULDIV_FAST_MUL_EN for a     |
// |           single-cycle multiplier (divide is always iterative).            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_rd,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_count;
    logic               r_is_div;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_go;
    logic               w_div0;
    logic               w_launch;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic               w_neg_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_mul    = (op[2:1] == 2'b00);
    assign w_is_div    = (op[2:1] == 2'b01);
    assign w_is_signed = ~op[0];
    assign w_neg_a     = w_is_signed & rs_val[WIDTH-1];
    assign w_neg_b     = w_is_signed & rt_val[WIDTH-1];
    assign w_abs_a     = w_neg_a ? -rs_val : rs_val;
    assign w_abs_b     = w_neg_b ? -rt_val : rt_val;

    // cancel in IDLE drops a same-cycle start entirely
    assign w_go   = start & ~cancel & (r_state == c_IDLE);
    assign w_div0 = w_go & w_is_div & (rt_val == {WIDTH{1'b0}});
`ifdef PIPE_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_mag;
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_mag  = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
    assign w_fast_prod = (w_neg_a ^ w_neg_b) ? -w_fast_mag : w_fast_mag;
    assign w_launch    = w_go & w_is_div & ~w_div0;
`else
    assign w_launch    = w_go & (w_is_mul | (w_is_div & ~w_div0));
`endif

    // multiply: conditional add of the multiplicand into the upper half, then shift right
    assign w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    // divide: low half holds the dividend shifting out and the quotient shifting in
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = (w_shift >= {1'b0, r_b});

    assign w_neg_q = r_signed & (r_sign_a ^ r_sign_b);
    assign w_prod  = w_neg_q ? -r_acc : r_acc;
    assign w_quo   = w_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem   = (r_signed & r_sign_a) ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_go && op == c_OP_MTHI) r_hi <= rs_val;
                    if (w_go && op == c_OP_MTLO) r_lo <= rs_val;
                    if (w_div0) r_done <= 1'b1;
`ifdef PIPE_MULDIV_FAST_MUL_EN
                    if (w_go && w_is_mul) begin
                        r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                        r_lo   <= w_fast_prod[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
`endif
                    if (w_launch) begin
                        r_is_div <= w_is_div;
                        r_signed <= w_is_signed;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_b      <= w_abs_b;
                        r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_rem    <= '0;
                        r_count  <= '0;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (cancel) begin
                        r_state <= c_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= {w_add, r_acc[WIDTH-1:1]};
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == c_LAST) r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    if (!cancel) begin
                        r_hi   <= r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                        r_lo   <= r_is_div ? w_quo : w_prod[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy  = (r_state != c_IDLE);
    assign stall = busy & (hilo_rd | start);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_pipe_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipe_muldiv_ctrl                                              |
// | Brief   : directed + random bench for pipe_muldiv_ctrl against a           |
// |           plain-arithmetic HI/LO reference model.                          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_muldiv_ctrl;

    localparam logic [2:0] c_MULT = 3'd0, c_MULTU = 3'd1, c_DIV = 3'd2, c_DIVU = 3'd3;
    localparam logic [2:0] c_MTHI = 3'd4, c_MTLO = 3'd5, c_NOP = 3'd6;
`ifdef PIPE_MULDIV_FAST_MUL_EN
    localparam int c_MUL_LAT = 0;
`else
    localparam int c_MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        hilo_rd = 1'b0;
    logic        cancel = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    pipe_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_rd(hilo_rd), .cancel(cancel),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic has_done, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = m_hi; el = m_lo; has_done = 1'b0; lat = 0;
        case (o)
            c_MULT:  begin p = sa * sb; eh = p[63:32]; el = p[31:0]; has_done = 1'b1; lat = c_MUL_LAT; end
            c_MULTU: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; has_done = 1'b1; lat = c_MUL_LAT; end
            c_DIV: begin
                has_done = 1'b1;
                if (b != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; lat = 33; end
            end
            c_DIVU: begin
                has_done = 1'b1;
                if (b != 0) begin p = ua / ub; el = p[31:0]; p = ua % ub; eh = p[31:0]; lat = 33; end
            end
            c_MTHI: eh = a;
            c_MTLO: el = a;
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        hd, busy_bad;
        int          lat, cyc;
        model(o, a, b, eh, el, hd, lat);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        #1 chk("issue_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0;
        if (hd) begin
            cyc = 0; busy_bad = 1'b0;
            while (!done && cyc < 40) begin
                if (!busy) busy_bad = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
            chk("latency", cyc, lat);
            chk("busy_during", busy_bad, 0);
            chk("busy_after", busy, 0);
            chk("hi", hi, eh);
            chk("lo", lo, el);
            @(posedge clk); #1;
            chk("done_pulse", done, 0);
        end else begin
            chk("done_none", done, 0);
            chk("busy_none", busy, 0);
            chk("hi", hi, eh);
            chk("lo", lo, el);
        end
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        logic [31:0] a, b, eh, el;
        logic        hd, saw_done;
        int          lat, cyc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_op(c_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("t1_hi", hi, 32'h0000_0001);
        chk("t1_lo", lo, 32'hFFFF_FFFE);
        do_op(c_DIV, -32'sd7, 32'd2);
        chk("t2_lo", lo, 32'hFFFF_FFFD);
        do_op(c_MULT, -32'sd3, 32'd5);
        chk("t2_hi", hi, 32'hFFFF_FFFF);
        do_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(c_MTHI, 32'h1234, 32'd0);
        do_op(c_MTLO, 32'h1234, 32'd0);
        do_op(c_DIVU, 32'd100, 32'd0);
        do_op(c_NOP, 32'd9, 32'd9);

        // div held against a waiting mfhi; extra starts must not disturb it
        model(c_DIV, 32'd123456789, 32'd1000, eh, el, hd, lat);
        start = 1'b1; op = c_DIV; rs_val = 32'd123456789; rt_val = 32'd1000;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 40) begin
            hilo_rd = 1'b1; start = (cyc < 4); op = c_MULT; rs_val = 32'd5; rt_val = 32'd7;
            #1 chk("stall_busy", stall, 1);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        #1 chk("stall_done", stall, 0);
        chk("hold_latency", cyc, 33);
        chk("hold_hi", hi, eh);
        chk("hold_lo", lo, el);
        hilo_rd = 1'b0;
        m_hi = eh; m_lo = el;
        @(posedge clk); #1;

        // cancel at RUN count==10
        start = 1'b1; op = c_DIV; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("cancel_done", saw_done, 0);
        chk("cancel_hi", hi, m_hi);
        chk("cancel_lo", lo, m_lo);

        // cancel in IDLE swallows a same-cycle mthi
        cancel = 1'b1; start = 1'b1; op = c_MTHI; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        chk("cancel_idle_hi", hi, m_hi);
        chk("cancel_idle_busy", busy, 0);

        // reset mid-run
        start = 1'b1; op = c_MULT; rs_val = 32'h0001_2345; rt_val = 32'h0006_789A;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        chk("rrun_hi", hi, 0);
        chk("rrun_lo", lo, 0);
        chk("rrun_busy", busy, 0);
        chk("rrun_done", done, 0);
        resetn = 1'b1;
        m_hi = '0; m_lo = '0;
        do_op(c_MTLO, 32'h0000_ABCD, 32'd0);
        chk("mtlo_val", lo, 32'h0000_ABCD);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            do_op(3'($urandom_range(0, 7)), a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
